// File: rtl/breath_pkg.sv
// Shared types and width helpers for the breathing-LED blocks.
package breath_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Default configuration widths, shared with the single-LED breathing block
  localparam int unsigned DEF_N_LED  = 4;
  localparam int unsigned DEF_PERIOD = 50_000;
  localparam int unsigned CNT_W      = $clog2(DEF_PERIOD + 1);
  localparam int unsigned CH_W       = $clog2(DEF_N_LED);

  function automatic int unsigned cnt_width(input int unsigned period);
    return $clog2(period + 1);
  endfunction

  function automatic int unsigned ch_width(input int unsigned n_led);
    return $clog2(n_led);
  endfunction

endpackage

// File: rtl/breath_pwm_cnt.sv
// PWM period counter: free-running 0..PERIOD-1 with a last-cycle tick.
module breath_pwm_cnt
  import breath_pkg::*;
#(
  parameter int unsigned PERIOD = 50_000,
  parameter int unsigned W      = cnt_width(PERIOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] cnt,
  output logic         tick_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_c = (cnt_q == W'(PERIOD - 1));
    cnt_d  = tick_c ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/breath_seq_ctrl.sv
// Chaser sequencer sharing one breathing PWM engine across N_LED active-low LEDs.
// Optional SEQ_PAUSE_EN adds a pause input that freezes the ramp on period ticks.
module breath_seq_ctrl
  import breath_pkg::*;
#(
  parameter int unsigned N_LED        = 4,
  parameter int unsigned PERIOD       = 50_000,
  parameter int unsigned STEP         = 25,
  parameter int unsigned HOLD_PERIODS = 100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        dir,
`ifdef SEQ_PAUSE_EN
  input  logic                        pause,
`endif
  output logic [N_LED-1:0]            led,
  output logic [$clog2(N_LED)-1:0]    ch_idx,
  output logic [$clog2(PERIOD+1)-1:0] duty,
  output logic                        busy
);

  localparam int unsigned DUTY_W = cnt_width(PERIOD);
  localparam int unsigned IDX_W  = ch_width(N_LED);
  localparam int unsigned GAP_W  = $clog2(HOLD_PERIODS + 1);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [IDX_W-1:0]  ch_q, ch_d, ch_next_c;
  logic [DUTY_W-1:0] cnt;
  logic              tick_c;
  logic              step_c;
  logic [N_LED-1:0]  led_c;

  breath_pwm_cnt #(
    .PERIOD (PERIOD),
    .W      (DUTY_W)
  ) u_pwm_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt    (cnt),
    .tick_c (tick_c)
  );

`ifdef SEQ_PAUSE_EN
  assign step_c = tick_c & ~pause;
`else
  assign step_c = tick_c;
`endif

  // Neighbour channel in the requested direction, wrapping at both ends
  always_comb begin
    ch_next_c = ch_q;
    if (!dir) ch_next_c = (ch_q == IDX_W'(N_LED - 1)) ? '0 : ch_q + IDX_W'(1);
    else      ch_next_c = (ch_q == '0) ? IDX_W'(N_LED - 1) : ch_q - IDX_W'(1);
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    gap_d   = gap_q;
    ch_d    = ch_q;
    if (step_c) begin
      case (state_q)
        IDLE: if (en) state_d = RISE;
        RISE: begin
          if (duty_q == DUTY_W'(PERIOD)) state_d = FALL;
          else                           duty_d  = duty_q + DUTY_W'(STEP);
        end
        FALL: begin
          if (duty_q == '0) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            duty_d = duty_q - DUTY_W'(STEP);
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(HOLD_PERIODS - 1)) begin
            ch_d    = ch_next_c;
            state_d = en ? RISE : IDLE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      gap_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      gap_q   <= gap_d;
      ch_q    <= ch_d;
    end
  end

  // Only the active channel is driven; an idle sequencer keeps every pin dark
  always_comb begin
    led_c = '1;
    for (int unsigned i = 0; i < N_LED; i++) begin
      if (state_q != IDLE && ch_q == IDX_W'(i)) led_c[i] = (cnt > duty_q);
    end
  end

  assign led    = led_c;
  assign ch_idx = ch_q;
  assign duty   = duty_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_breath_seq_ctrl.sv
// Self-checking bench for breath_seq_ctrl against a per-channel period-index model.
// Build with +define+SEQ_PAUSE_EN to exercise the pause input as well.
module tb_breath_seq_ctrl;

  localparam int N_LED  = 4;
  localparam int PERIOD = 100;
  localparam int STEP   = 25;
  localparam int HOLD   = 2;
  localparam int K      = PERIOD / STEP;
  localparam int CH_LEN = 2 * (K + 1) + HOLD;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             dir = 1'b0;
  logic             pause = 1'b0;
  logic [N_LED-1:0] led;
  logic [1:0]       ch_idx;
  logic [6:0]       duty;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: idle flag, period index within the current channel visit, channel, counter
  bit m_idle;
  int m_p;
  int m_ch;
  int m_cnt;

  breath_seq_ctrl #(
    .N_LED        (N_LED),
    .PERIOD       (PERIOD),
    .STEP         (STEP),
    .HOLD_PERIODS (HOLD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .dir    (dir),
`ifdef SEQ_PAUSE_EN
    .pause  (pause),
`endif
    .led    (led),
    .ch_idx (ch_idx),
    .duty   (duty),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h (cyc=%0d t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  function automatic int m_duty();
    if (m_idle)               return 0;
    if (m_p <= K)             return m_p * STEP;
    if (m_p <= 2 * K + 1)     return (2 * K + 1 - m_p) * STEP;
    return 0;
  endfunction

  function automatic logic [N_LED-1:0] m_led();
    logic [N_LED-1:0] v;
    v = '1;
    if (!m_idle && m_cnt <= m_duty()) v[m_ch] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1;
    m_p    = 0;
    m_ch   = 0;
    m_cnt  = 0;
  endtask

  task automatic model_clock();
    bit tick;
    tick  = (m_cnt == PERIOD - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    if (tick && !pause) begin
      if (m_idle) begin
        if (en) begin
          m_idle = 1'b0;
          m_p    = 0;
        end
      end else if (m_p == CH_LEN - 1) begin
        m_ch = dir ? (m_ch + N_LED - 1) % N_LED : (m_ch + 1) % N_LED;
        if (en) m_p = 0;
        else    m_idle = 1'b1;
      end else begin
        m_p++;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("led",    32'(led),    32'(m_led()));
    check_eq("duty",   32'(duty),   32'(m_duty()));
    check_eq("ch_idx", 32'(ch_idx), 32'(m_ch));
    check_eq("busy",   32'(busy),   32'(!m_idle));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_clock();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    check_eq("rst_led",  32'(led),    32'hF);
    check_eq("rst_duty", 32'(duty),   32'h0);
    check_eq("rst_ch",   32'(ch_idx), 32'h0);
    check_eq("rst_busy", 32'(busy),   32'h0);

    // Directed chase: full-bright period, hand-off, wrap, direction and en drop
    en = 1'b1;
    dir = 1'b0;
    release_reset();
    run_to(550);
    check_eq("full_led",  32'(led),  32'hE);
    check_eq("full_duty", 32'(duty), 32'd100);
    run_to(1301);
    check_eq("first_adv", 32'(ch_idx), 32'd1);
    check_eq("first_adv_busy", 32'(busy), 32'd1);
    run_to(4901);
    check_eq("wrap_up", 32'(ch_idx), 32'd0);
    run_to(4950);
    dir = 1'b1;
    run_to(5250);
    dir = 1'b0;
    run_to(5350);
    dir = 1'b1;
    run_to(6101);
    check_eq("wrap_down", 32'(ch_idx), 32'd3);
    run_to(6350);
    check_eq("drop_duty", 32'(duty), 32'd50);
    en = 1'b0;
    run_to(7301);
    check_eq("drop_busy", 32'(busy),   32'd0);
    check_eq("drop_led",  32'(led),    32'hF);
    check_eq("drop_ch",   32'(ch_idx), 32'd2);
    run_to(7450);
    en = 1'b1;
    run_to(7501);
    check_eq("rearm_busy", 32'(busy),   32'd1);
    check_eq("rearm_ch",   32'(ch_idx), 32'd2);
    run_to(8150);
    check_eq("fall_duty", 32'(duty), 32'd75);

    // Asynchronous reset in the middle of FALL
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_led",  32'(led),    32'hF);
    check_eq("mid_rst_duty", 32'(duty),   32'h0);
    check_eq("mid_rst_busy", 32'(busy),   32'h0);
    check_eq("mid_rst_ch",   32'(ch_idx), 32'h0);
    repeat (3) step();

`ifdef SEQ_PAUSE_EN
    en = 1'b1;
    dir = 1'b0;
    release_reset();
    run_to(320);
    pause = 1'b1;
    run_to(750);
    check_eq("pause_duty", 32'(duty), 32'd50);
    run_to(820);
    pause = 1'b0;
    run_to(901);
    check_eq("unpause_duty", 32'(duty), 32'd75);
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
`endif

    // Randomised run with slowly toggling controls
    en = 1'b1;
    release_reset();
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 2999) == 0) en = ~en;
      if ($urandom_range(0, 799) == 0)  dir = ~dir;
`ifdef SEQ_PAUSE_EN
      if ($urandom_range(0, 1499) == 0) pause = ~pause;
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
